image_read_arbiter: RTL
=======================

IMAGE_READ_ARBITER -- requirements
Module: image_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the image_memory read port (legal range 2..8).
REQ-002 Parameter READ_LATENCY, default 2, SHALL set the cycles from address issue to valid mem_q (legal range 1..4).
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 Port req  in  NUM_REQ  SHALL be the per-requester read request, held high until granted.
REQ-006 Port lock  in  NUM_REQ  SHALL be the per-requester burst-lock request, sampled with req.
REQ-007 Port addr  in  NUM_REQ*16  SHALL be the flattened per-requester read addresses; slice i is requester i.
REQ-008 Port grant  out  NUM_REQ  SHALL be one-hot or zero, flagging the address taken this cycle.
REQ-009 Port rvalid  out  NUM_REQ  SHALL be one-hot or zero, flagging rdata for that requester.
REQ-010 Port rdata  out  8  SHALL be the shared read-data broadcast.
REQ-011 Port mem_rdaddress  out  16  SHALL drive the image_memory rdaddress.
REQ-012 Port mem_q  in  8  SHALL carry the image_memory q output.
REQ-013 Port busy  out  1  SHALL be high while any read is in flight or the arbiter is in LOCKED.
REQ-014 Port grant_count  out  NUM_REQ*16  SHALL carry per-requester grant counters (see Configuration).

Function
REQ-015 Each cycle, at most one requester SHALL be granted; grant[w] SHALL be combinational from req, the state and the pointer; mem_rdaddress SHALL equal addr slice w in that cycle.
REQ-016 When nothing is granted, mem_rdaddress SHALL hold the last issued address.
REQ-017 In state ARB: winner = first i with req[i]=1, searching from rr_ptr upward with wrap; after a grant to w, rr_ptr SHALL become (w+1) mod NUM_REQ.
REQ-018 A grant in cycle t SHALL produce rvalid[w]=1 and rdata=mem_q in cycle t+READ_LATENCY, exactly once; an id/valid shift register of depth READ_LATENCY SHALL track this.
REQ-019 Back-to-back grants, including to the same requester, SHALL be allowed every cycle; a requester changes addr only after its grant cycle.
REQ-020 ARB->LOCKED SHALL occur when grant[w]=1 and lock[w]=1; owner:=w.
REQ-021 In LOCKED, only the owner SHALL be eligible; other requests wait without loss; rr_ptr SHALL be frozen.
REQ-022 LOCKED->ARB SHALL occur at the end of any cycle in which lock[owner]=0; the owner may still be granted in that cycle, and rr_ptr SHALL then become owner+1.
REQ-023 lock[i]=1 with req[i]=0 SHALL have no effect in ARB.
REQ-024 Simultaneous requests from all requesters SHALL be served in pointer order, each within NUM_REQ grants when none locks.

Reset
REQ-025 On reset: grant=0, rvalid=0, rdata=0, mem_rdaddress=0, busy=0, rr_ptr=0, state=ARB, counters=0, and all in-flight valid bits cleared.
REQ-026 Reads in flight at reset SHALL never produce rvalid.

Configuration
REQ-027 With IMGARB_GRANT_COUNT_EN defined, grant_count slice i SHALL increment on each grant[i], saturating at 16'hFFFF.
REQ-028 Without IMGARB_GRANT_COUNT_EN, grant_count SHALL be tied to zero and no counter registers SHALL exist.

Structure
REQ-029 Package image_mem_pkg SHALL hold IMG_ADDR_W=16, IMG_DATA_W=8, the arb_state_t enum {ARB, LOCKED} and the req_id_t typedef.
REQ-030 Sub-module rr_pick SHALL implement the combinational rotate-priority search (req, rr_ptr -> one-hot winner); all state SHALL remain in image_read_arbiter.

Verification
REQ-031 Requester 1 alone, addr=16'h0123, READ_LATENCY=2 -> grant[1] in cycle t; rvalid[1] in t+2 with rdata equal to the memory byte at 0x0123.
REQ-032 All four req held high from reset -> grant order 0,1,2,3,0; rvalid order identical; no gaps.
REQ-033 Req0 with lock=1 for 3 grants while req2 is high -> grants 0,0,0; lock0 drops; next grant goes to 2.
REQ-034 Reset pulsed 1 cycle after a grant -> no rvalid ever appears for that read; all outputs are zero the cycle after reset.
REQ-035 With IMGARB_GRANT_COUNT_EN, requester 3 granted 70000 times -> grant_count[3] reads 16'hFFFF; without the macro, it reads 0.

Source files
------------

// File: rtl/image_mem_pkg.sv
// Shared types and constants for the image memory read path.
package image_mem_pkg;

  localparam int unsigned IMG_ADDR_W = 16;
  localparam int unsigned IMG_DATA_W = 8;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

  // Wide enough for the maximum of 8 requesters.
  typedef logic [2:0] req_id_t;

  // Advances a requester index with wrap at n.
  function automatic req_id_t wrap_inc(input req_id_t id, input int unsigned n);
    return (id == req_id_t'(n - 1)) ? '0 : req_id_t'(id + 3'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: first set request at or above rr_ptr, with wrap.
module rr_pick
  import image_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output req_id_t            winner_id,
  output logic               found
);

  // Scan NUM_REQ positions starting at the pointer; first hit wins.
  always_comb begin
    winner    = '0;
    winner_id = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_id   = req_id_t'(idx);
      end
    end
  end

endmodule

// File: rtl/image_read_arbiter.sv
// Round-robin arbiter sharing one image_memory read port among NUM_REQ
// requesters, with burst locking and a fixed-latency return path.
// Optional feature: define IMGARB_GRANT_COUNT_EN for saturating per-requester
// grant counters on grant_count (tied to zero otherwise).
module image_read_arbiter
  import image_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      lock,
  input  logic [NUM_REQ*16-1:0]   addr,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      rvalid,
  output logic [IMG_DATA_W-1:0]   rdata,
  output logic [IMG_ADDR_W-1:0]   mem_rdaddress,
  input  logic [IMG_DATA_W-1:0]   mem_q,
  output logic                    busy,
  output logic [NUM_REQ*16-1:0]   grant_count
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t               state, state_nx;
  req_id_t                  rr_ptr, rr_ptr_nx;
  req_id_t                  owner, owner_nx;
  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       pick;
  req_id_t                  pick_id;
  logic                     pick_found;
  logic                     granted;
  logic [NUM_REQ-1:0]       owner_mask;
  logic                     owner_lock;
  logic                     grant_lock;
  logic [IMG_ADDR_W-1:0]    last_addr;
  logic [READ_LATENCY-1:0]  vld_sr;
  req_id_t                  id_sr [READ_LATENCY];

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (eligible),
    .rr_ptr    (rr_ptr),
    .winner    (pick),
    .winner_id (pick_id),
    .found     (pick_found)
  );

  // Eligibility, grant and issued address; grant is suppressed during reset.
  always_comb begin
    owner_mask    = ONE << owner;
    eligible      = (state == LOCKED) ? (req & owner_mask) : req;
    grant         = reset ? '0 : pick;
    granted       = pick_found && !reset;
    owner_lock    = |(lock & owner_mask);
    grant_lock    = |(lock & grant);
    mem_rdaddress = granted ? addr[32'(pick_id)*16 +: 16] : last_addr;
  end

  // Next-state logic for the ARB/LOCKED FSM and the round-robin pointer.
  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    owner_nx  = owner;
    case (state)
      ARB: begin
        if (granted) begin
          rr_ptr_nx = wrap_inc(pick_id, NUM_REQ);
          if (grant_lock) begin
            state_nx = LOCKED;
            owner_nx = pick_id;
          end
        end
      end
      LOCKED: begin
        // Pointer stays frozen while locked; on release it resumes past the owner.
        if (!owner_lock) begin
          state_nx  = ARB;
          rr_ptr_nx = wrap_inc(owner, NUM_REQ);
        end
      end
      default: state_nx = ARB;
    endcase
  end

  // State, pointer, last address and the id/valid return pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      last_addr <= '0;
      vld_sr    <= '0;
      for (int unsigned k = 0; k < READ_LATENCY; k++) id_sr[k] <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      last_addr <= mem_rdaddress;
      vld_sr[0] <= granted;
      id_sr[0]  <= pick_id;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        vld_sr[k] <= vld_sr[k-1];
        id_sr[k]  <= id_sr[k-1];
      end
    end
  end

  // Return path and busy; gated by reset so stale reads never surface.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    busy   = 1'b0;
    if (!reset) begin
      if (vld_sr[READ_LATENCY-1]) begin
        rvalid = ONE << id_sr[READ_LATENCY-1];
        rdata  = mem_q;
      end
      busy = (|vld_sr) || (state == LOCKED);
    end
  end

`ifdef IMGARB_GRANT_COUNT_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_count[i*16 +: 16] = cnt_q[i];
  end
`else
  assign grant_count = '0;
`endif

endmodule
